// File: rtl/multiply_seq.sv
// Iterative 32x32 shift-add multiplier, 64-bit product, 32 CALC cycles.
// Ports: clk, reset (sync, active-high), mult_begin, mult_op1, mult_op2 in;
//   product, mult_end, overflow out. `MULT_SIGNED_EN selects signed mode.
module multiply_seq (
  input  logic        clk,
  input  logic        reset,
  input  logic        mult_begin,
  input  logic [31:0] mult_op1,
  input  logic [31:0] mult_op2,
  output logic [63:0] product,
  output logic        mult_end,
  output logic        overflow
);

  typedef enum logic [1:0] {
    IDLE,
    CALC,
    DONE
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [63:0] mcand;
  logic [63:0] acc;
  logic [63:0] acc_sum;
  logic [63:0] result;
  logic [31:0] mplier;
  logic [31:0] mag1;
  logic [31:0] mag2;
  logic [4:0]  count;
  logic        last;
  logic        ovf_calc;

`ifdef MULT_SIGNED_EN
  logic        neg;

  // Magnitude of 0x80000000 wraps to itself, which is the correct
  // unsigned 32-bit magnitude.
  assign mag1 = mult_op1[31] ? (~mult_op1 + 32'd1) : mult_op1;
  assign mag2 = mult_op2[31] ? (~mult_op2 + 32'd1) : mult_op2;
  assign result = neg ? (~acc_sum + 64'd1) : acc_sum;
  assign ovf_calc = ~((&result[63:31]) | ~(|result[63:31]));
`else
  assign mag1 = mult_op1;
  assign mag2 = mult_op2;
  assign result = acc_sum;
  assign ovf_calc = |result[63:32];
`endif

  assign acc_sum = acc + (mplier[0] ? mcand : 64'd0);
  assign last    = (count == 5'd31);

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt = state;
    if (!mult_begin) begin
      state_nxt = IDLE;
    end else begin
      unique case (state)
        IDLE:    state_nxt = CALC;
        CALC:    state_nxt = last ? DONE : CALC;
        DONE:    state_nxt = DONE;
        default: state_nxt = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      mcand    <= 64'd0;
      acc      <= 64'd0;
      mplier   <= 32'd0;
      count    <= 5'd0;
      product  <= 64'd0;
      mult_end <= 1'b0;
      overflow <= 1'b0;
`ifdef MULT_SIGNED_EN
      neg      <= 1'b0;
`endif
    end else begin
      unique case (state)
        IDLE: begin
          mult_end <= 1'b0;
          if (mult_begin) begin
            mcand  <= {32'd0, mag1};
            mplier <= mag2;
            acc    <= 64'd0;
            count  <= 5'd0;
`ifdef MULT_SIGNED_EN
            neg    <= mult_op1[31] ^ mult_op2[31];
`endif
          end
        end
        CALC: begin
          // Abort leaves product/overflow untouched.
          if (mult_begin) begin
            acc    <= acc_sum;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            count  <= count + 5'd1;
            if (last) begin
              product  <= result;
              overflow <= ovf_calc;
              mult_end <= 1'b1;
            end
          end
        end
        DONE: begin
          if (!mult_begin) begin
            mult_end <= 1'b0;
          end
        end
        default: mult_end <= 1'b0;
      endcase
    end
  end

endmodule

// File: tb/tb_multiply_seq.sv
// Directed self-checking bench for multiply_seq.
// Expected values follow the build selected by MULT_SIGNED_EN.
module tb_multiply_seq;

  logic        clk = 1'b0;
  logic        reset;
  logic        mult_begin;
  logic [31:0] mult_op1;
  logic [31:0] mult_op2;
  logic [63:0] product;
  logic        mult_end;
  logic        overflow;

  int checks   = 0;
  int failures = 0;

  multiply_seq dut (
    .clk        (clk),
    .reset      (reset),
    .mult_begin (mult_begin),
    .mult_op1   (mult_op1),
    .mult_op2   (mult_op2),
    .product    (product),
    .mult_end   (mult_end),
    .overflow   (overflow)
  );

  always #5 clk = ~clk;

  task automatic test_reset();
    @(negedge clk);
    reset      = 1'b1;
    mult_begin = 1'b0;
    mult_op1   = 32'd0;
    mult_op2   = 32'd0;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (product !== 64'd0) begin
      failures++;
      $display("FAIL reset_product got=%h exp=0", product);
    end
    checks++;
    if (mult_end !== 1'b0) begin
      failures++;
      $display("FAIL reset_end got=%b exp=0", mult_end);
    end
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_ovf got=%b exp=0", overflow);
    end
    @(negedge clk);
    reset = 1'b0;
  endtask

  // Full operation: latency, result, hold while operands change, release.
  task automatic test_vector(input logic [31:0] a, input logic [31:0] b,
                             input logic [63:0] ep, input logic eo,
                             input string name);
    int n;
    @(negedge clk);
    mult_op1   = a;
    mult_op2   = b;
    mult_begin = 1'b1;
    n = 0;
    for (int i = 1; i <= 40; i++) begin
      @(posedge clk);
      #1;
      n = i;
      if (mult_end) break;
    end
    checks++;
    if (!mult_end || (n - 1) !== 32) begin
      failures++;
      $display("FAIL %s_latency got=%0d end=%b exp=32", name, n - 1,
               mult_end);
    end
    checks++;
    if (product !== ep) begin
      failures++;
      $display("FAIL %s_product got=%h exp=%h", name, product, ep);
    end
    checks++;
    if (overflow !== eo) begin
      failures++;
      $display("FAIL %s_ovf got=%b exp=%b", name, overflow, eo);
    end
    @(negedge clk);
    mult_op1 = ~a;
    mult_op2 = 32'h0000_0003;
    repeat (5) @(posedge clk);
    #1;
    checks++;
    if (product !== ep || mult_end !== 1'b1 || overflow !== eo) begin
      failures++;
      $display("FAIL %s_hold got=%h/%b/%b exp=%h/1/%b", name, product,
               mult_end, overflow, ep, eo);
    end
    @(negedge clk);
    mult_begin = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (mult_end !== 1'b0) begin
      failures++;
      $display("FAIL %s_release got=%b exp=0", name, mult_end);
    end
  endtask

  task automatic test_main();
    logic [31:0] va [6];
    logic [31:0] vb [6];
    logic [63:0] vp [6];
    logic        vo [6];
    va[0] = 32'h7FFF_FFFF; vb[0] = 32'h7FFF_FFFF;
    va[1] = 32'h0000_0005; vb[1] = 32'hFFFF_FFFD;
    va[2] = 32'hFFFF_FFFF; vb[2] = 32'hFFFF_FFFF;
    va[3] = 32'h8000_0000; vb[3] = 32'h8000_0000;
    va[4] = 32'h0000_0000; vb[4] = 32'h1234_5678;
    va[5] = 32'hFFFF_FFFF; vb[5] = 32'h0000_0002;
    vp[0] = 64'h3FFF_FFFF_0000_0001; vo[0] = 1'b1;
    vp[3] = 64'h4000_0000_0000_0000; vo[3] = 1'b1;
    vp[4] = 64'h0;                   vo[4] = 1'b0;
`ifdef MULT_SIGNED_EN
    vp[1] = 64'hFFFF_FFFF_FFFF_FFF1; vo[1] = 1'b0;
    vp[2] = 64'h0000_0000_0000_0001; vo[2] = 1'b0;
    vp[5] = 64'hFFFF_FFFF_FFFF_FFFE; vo[5] = 1'b0;
`else
    vp[1] = 64'h0000_0004_FFFF_FFF1; vo[1] = 1'b1;
    vp[2] = 64'hFFFF_FFFE_0000_0001; vo[2] = 1'b1;
    vp[5] = 64'h0000_0001_FFFF_FFFE; vo[5] = 1'b1;
`endif
    for (int i = 0; i < 6; i++) begin
      test_vector(va[i], vb[i], vp[i], vo[i], $sformatf("vec%0d", i));
    end
  endtask

  task automatic test_abort();
    bit seen;
    test_vector(32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001,
                1'b1, "pre_abort");
    @(negedge clk);
    mult_op1   = 32'd3;
    mult_op2   = 32'd5;
    mult_begin = 1'b1;
    repeat (11) @(negedge clk);
    mult_begin = 1'b0;
    seen = 1'b0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (mult_end) seen = 1'b1;
    end
    checks++;
    if (seen) begin
      failures++;
      $display("FAIL abort_end got=1 exp=0");
    end
    checks++;
    if (product !== 64'h3FFF_FFFF_0000_0001 || overflow !== 1'b1) begin
      failures++;
      $display("FAIL abort_keep got=%h/%b exp=3fffffff00000001/1",
               product, overflow);
    end
    test_vector(32'd3, 32'd5, 64'd15, 1'b0, "rerun");
  endtask

  task automatic test_reset_mid();
    @(negedge clk);
    mult_op1   = 32'h1234_5678;
    mult_op2   = 32'h0000_0010;
    mult_begin = 1'b1;
    repeat (11) @(negedge clk);
    reset      = 1'b1;
    mult_begin = 1'b0;
    @(posedge clk);
    #1;
    checks++;
    if (product !== 64'd0 || mult_end !== 1'b0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL midreset got=%h/%b/%b exp=0/0/0", product,
               mult_end, overflow);
    end
    @(negedge clk);
    reset = 1'b0;
    test_vector(32'h1234_5678, 32'h0000_0010, 64'h0000_0001_2345_6780,
                1'b1, "post_reset");
  endtask

  task automatic test_back_to_back();
    test_vector(32'd6, 32'd7, 64'd42, 1'b0, "b2b_a");
    test_vector(32'h0001_0000, 32'h0001_0000, 64'h0000_0001_0000_0000,
                1'b1, "b2b_b");
  endtask

  initial begin
    reset      = 1'b1;
    mult_begin = 1'b0;
    mult_op1   = 32'd0;
    mult_op2   = 32'd0;
    test_reset();
    test_main();
    test_abort();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
